// File: rtl/connect_board_engine.sv
// connect_board_engine: Connect-N / Pop-Out board state, move handshake,
// sequential win/draw scan and saturating per-player scores.
module connect_board_engine #(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4,
    parameter int SCORE_W = 4,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int HW = $clog2(ROWS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               move_valid,
    input  logic [CW-1:0]      move_col,
    input  logic               move_pop,
    output logic               move_ready,
    output logic               move_ack,
    output logic               move_err,
    input  logic               new_game,
    input  logic               clear_score,
    input  logic [CW-1:0]      rd_col,
    input  logic [RW-1:0]      rd_row,
    output logic               rd_occupied,
    output logic               rd_color,
    output logic               cur_player,
    output logic               busy,
    output logic               game_over,
    output logic               winner_valid,
    output logic               winner,
    output logic               draw,
    output logic [SCORE_W-1:0] score_red,
    output logic [SCORE_W-1:0] score_yellow
);
    localparam int NC = COLS * ROWS;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, OVER = 2'd2} state_t;

    state_t             state_q;
    logic [NC-1:0]      occ_q, color_q, occ_d, color_d;
    logic [HW-1:0]      height_q [COLS];
    logic [HW-1:0]      height_d [COLS];
    logic               cur_player_q, ack_q, err_q, winner_valid_q, winner_q, draw_q;
    logic               red_found_q, yel_found_q, rd_occ_q, rd_color_q;
    logic [CW-1:0]      scan_c_q;
    logic [RW-1:0]      scan_r_q;
    logic [SCORE_W-1:0] score_red_q, score_yel_q;

    logic               col_ok_s, move_ok_s, full_s, scan_last_s;
    logic               red_all_s, yel_all_s, mover_found_s, other_found_s, win_s, win_color_s;
    logic [CW-1:0]      sel_c_s;
    logic [HW-1:0]      sel_h_s;
    logic [IW-1:0]      bottom_idx_s;
    logic [1:0]         hits_s;

    // Cells are stored column-major so a column is a contiguous slice.
    function automatic logic [IW-1:0] cell_idx(input int c, input int r);
        return IW'(c * ROWS + r);
    endfunction

    // Returns {red, yellow}: WIN_LEN in-bounds cells along (dc, dr) share that colour.
    function automatic logic [1:0] run_match(input int c, input int r, input int dc, input int dr);
        logic red, yel;
        int   cc, rr;
        red = 1'b1;
        yel = 1'b1;
        for (int k = 0; k < WIN_LEN; k++) begin
            cc = c + k * dc;
            rr = r + k * dr;
            if (cc < 0 || cc >= COLS || rr < 0 || rr >= ROWS) begin
                red = 1'b0;
                yel = 1'b0;
            end else if (!occ_q[cell_idx(cc, rr)]) begin
                red = 1'b0;
                yel = 1'b0;
            end else if (color_q[cell_idx(cc, rr)]) begin
                yel = 1'b0;
            end else begin
                red = 1'b0;
            end
        end
        return {red, yel};
    endfunction

    // Move legality and the board contents that a legal move would produce.
    always_comb begin
        col_ok_s     = (int'(move_col) < COLS);
        sel_c_s      = col_ok_s ? move_col : '0;
        sel_h_s      = height_q[sel_c_s];
        bottom_idx_s = cell_idx(int'(sel_c_s), 0);
        if (move_pop) begin
            move_ok_s = col_ok_s && (sel_h_s != '0) && occ_q[bottom_idx_s] &&
                        (color_q[bottom_idx_s] == cur_player_q);
        end else begin
            move_ok_s = col_ok_s && (int'(sel_h_s) < ROWS);
        end
        occ_d    = occ_q;
        color_d  = color_q;
        height_d = height_q;
        if (move_ok_s && move_pop) begin
            // Cells above the height are empty, so shifting the whole column is exact.
            for (int r = 0; r < ROWS; r++) begin
                if (r < ROWS - 1) begin
                    occ_d[cell_idx(int'(sel_c_s), r)]   = occ_q[cell_idx(int'(sel_c_s), r + 1)];
                    color_d[cell_idx(int'(sel_c_s), r)] = color_q[cell_idx(int'(sel_c_s), r + 1)];
                end else begin
                    occ_d[cell_idx(int'(sel_c_s), r)]   = 1'b0;
                    color_d[cell_idx(int'(sel_c_s), r)] = 1'b0;
                end
            end
            height_d[sel_c_s] = sel_h_s - HW'(1);
        end else if (move_ok_s) begin
            occ_d[cell_idx(int'(sel_c_s), int'(sel_h_s))]   = 1'b1;
            color_d[cell_idx(int'(sel_c_s), int'(sel_h_s))] = cur_player_q;
            height_d[sel_c_s] = sel_h_s + HW'(1);
        end else begin
            height_d = height_q;
        end
    end

    // Current start-cell match and end-of-scan resolution.
    always_comb begin
        hits_s = run_match(int'(scan_c_q), int'(scan_r_q), 1, 0) |
                 run_match(int'(scan_c_q), int'(scan_r_q), 0, 1) |
                 run_match(int'(scan_c_q), int'(scan_r_q), 1, 1) |
                 run_match(int'(scan_c_q), int'(scan_r_q), 1, -1);
        red_all_s     = red_found_q | hits_s[1];
        yel_all_s     = yel_found_q | hits_s[0];
        scan_last_s   = (state_q == CHECK) && (int'(scan_c_q) == COLS - 1) &&
                        (int'(scan_r_q) == ROWS - 1);
        mover_found_s = cur_player_q ? red_all_s : yel_all_s;
        other_found_s = cur_player_q ? yel_all_s : red_all_s;
        win_s         = scan_last_s && (mover_found_s || other_found_s);
        win_color_s   = mover_found_s ? cur_player_q : ~cur_player_q;
        full_s        = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            full_s = full_s && (int'(height_q[c]) == ROWS);
        end
    end

    // Game FSM: board, player, scan walk and result flags.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state_q        <= IDLE;
            occ_q          <= '0;
            color_q        <= '0;
            height_q       <= '{default: '0};
            cur_player_q   <= 1'b1;
            ack_q          <= 1'b0;
            err_q          <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_q       <= 1'b0;
            draw_q         <= 1'b0;
            red_found_q    <= 1'b0;
            yel_found_q    <= 1'b0;
            scan_c_q       <= '0;
            scan_r_q       <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (move_valid && move_ok_s) begin
                        occ_q       <= occ_d;
                        color_q     <= color_d;
                        height_q    <= height_d;
                        ack_q       <= 1'b1;
                        state_q     <= CHECK;
                        scan_c_q    <= '0;
                        scan_r_q    <= '0;
                        red_found_q <= 1'b0;
                        yel_found_q <= 1'b0;
                    end else if (move_valid) begin
                        err_q <= 1'b1;
                    end
                end
                CHECK: begin
                    red_found_q <= red_all_s;
                    yel_found_q <= yel_all_s;
                    if (scan_last_s) begin
                        if (mover_found_s || other_found_s) begin
                            winner_valid_q <= 1'b1;
                            winner_q       <= win_color_s;
                            state_q        <= OVER;
                        end else if (full_s) begin
                            draw_q  <= 1'b1;
                            state_q <= OVER;
                        end else begin
                            cur_player_q <= ~cur_player_q;
                            state_q      <= IDLE;
                        end
                    end else if (int'(scan_r_q) == ROWS - 1) begin
                        scan_r_q <= '0;
                        scan_c_q <= scan_c_q + CW'(1);
                    end else begin
                        scan_r_q <= scan_r_q + RW'(1);
                    end
                end
                OVER:    state_q <= OVER;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Saturating scores; clearing beats a same-cycle win.
    always_ff @(posedge clk) begin
        if (reset || clear_score) begin
            score_red_q <= '0;
            score_yel_q <= '0;
        end else if (win_s && !new_game) begin
            if (win_color_s && (score_red_q != '1)) begin
                score_red_q <= score_red_q + SCORE_W'(1);
            end else if (!win_color_s && (score_yel_q != '1)) begin
                score_yel_q <= score_yel_q + SCORE_W'(1);
            end
        end
    end

    // Display read port, one cycle latency, zero outside the board.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_occ_q   <= 1'b0;
            rd_color_q <= 1'b0;
        end else if ((int'(rd_col) < COLS) && (int'(rd_row) < ROWS)) begin
            rd_occ_q   <= occ_q[cell_idx(int'(rd_col), int'(rd_row))];
            rd_color_q <= color_q[cell_idx(int'(rd_col), int'(rd_row))];
        end else begin
            rd_occ_q   <= 1'b0;
            rd_color_q <= 1'b0;
        end
    end

    assign move_ready   = (state_q == IDLE);
    assign busy         = (state_q == CHECK);
    assign game_over    = (state_q == OVER);
    assign move_ack     = ack_q;
    assign move_err     = err_q;
    assign cur_player   = cur_player_q;
    assign winner_valid = winner_valid_q;
    assign winner       = winner_q;
    assign draw         = draw_q;
    assign score_red    = score_red_q;
    assign score_yellow = score_yel_q;
    assign rd_occupied  = rd_occ_q;
    assign rd_color     = rd_color_q;
endmodule

// File: tb/tb_connect_board_engine.sv
// Bench for connect_board_engine: directed and random games scored against
// a board model that finds runs by per-direction run-length counting.
module tb_connect_board_engine;
    localparam int COLS = 7, ROWS = 6, WIN_LEN = 4, SCORE_W = 4;
    localparam int NCELL = COLS * ROWS;

    logic clk = 1'b0;
    logic reset, move_valid, move_pop, new_game, clear_score;
    logic [2:0] move_col, rd_col, rd_row;
    logic move_ready, move_ack, move_err, rd_occupied, rd_color, cur_player, busy;
    logic game_over, winner_valid, winner, draw;
    logic [SCORE_W-1:0] score_red, score_yellow;

    logic s_move_valid, s_move_pop, s_new_game, s_clear_score;
    logic [0:0] s_move_col, s_rd_col, s_rd_row;
    logic s_move_ready, s_move_ack, s_move_err, s_rd_occupied, s_rd_color, s_cur_player, s_busy;
    logic s_game_over, s_winner_valid, s_winner, s_draw;
    logic [3:0] s_score_red, s_score_yellow;

    always #5 clk = ~clk;

    connect_board_engine #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN), .SCORE_W(SCORE_W)) u_dut (
        .clk(clk), .reset(reset), .move_valid(move_valid), .move_col(move_col), .move_pop(move_pop),
        .move_ready(move_ready), .move_ack(move_ack), .move_err(move_err), .new_game(new_game),
        .clear_score(clear_score), .rd_col(rd_col), .rd_row(rd_row), .rd_occupied(rd_occupied),
        .rd_color(rd_color), .cur_player(cur_player), .busy(busy), .game_over(game_over),
        .winner_valid(winner_valid), .winner(winner), .draw(draw), .score_red(score_red),
        .score_yellow(score_yellow));

    connect_board_engine #(.COLS(2), .ROWS(2), .WIN_LEN(3), .SCORE_W(4)) u_small (
        .clk(clk), .reset(reset), .move_valid(s_move_valid), .move_col(s_move_col), .move_pop(s_move_pop),
        .move_ready(s_move_ready), .move_ack(s_move_ack), .move_err(s_move_err), .new_game(s_new_game),
        .clear_score(s_clear_score), .rd_col(s_rd_col), .rd_row(s_rd_row), .rd_occupied(s_rd_occupied),
        .rd_color(s_rd_color), .cur_player(s_cur_player), .busy(s_busy), .game_over(s_game_over),
        .winner_valid(s_winner_valid), .winner(s_winner), .draw(s_draw), .score_red(s_score_red),
        .score_yellow(s_score_yellow));

    int n_pass = 0, n_checks = 0;

    // Model: -1 empty, 1 red, 0 yellow.
    int m_board [COLS][ROWS];
    int m_h [COLS];
    bit m_player, m_over, m_wv, m_w, m_draw;
    int m_sr = 0, m_sy = 0;

    function automatic void model_clear();
        for (int c = 0; c < COLS; c++) begin
            m_h[c] = 0;
            for (int r = 0; r < ROWS; r++) m_board[c][r] = -1;
        end
        m_player = 1'b1; m_over = 1'b0; m_wv = 1'b0; m_w = 1'b0; m_draw = 1'b0;
    endfunction

    function automatic bit model_legal(input int col, input bit pop);
        if (col >= COLS) return 1'b0;
        if (pop) return (m_h[col] > 0) && (m_board[col][0] == int'(m_player));
        return m_h[col] < ROWS;
    endfunction

    function automatic void model_apply(input int col, input bit pop);
        if (pop) begin
            for (int r = 0; r < ROWS - 1; r++) m_board[col][r] = m_board[col][r + 1];
            m_board[col][ROWS - 1] = -1;
            m_h[col]--;
        end else begin
            m_board[col][m_h[col]] = int'(m_player);
            m_h[col]++;
        end
    endfunction

    function automatic bit has_run(input int color);
        int dcs [4] = '{1, 0, 1, 1};
        int drs [4] = '{0, 1, 1, -1};
        int run [COLS][ROWS];
        int pc, pr;
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < COLS; c++)
                for (int r = 0; r < ROWS; r++) begin
                    pc = c - dcs[d];
                    pr = r - drs[d];
                    if (m_board[c][r] != color) run[c][r] = 0;
                    else if (pc >= 0 && pr >= 0 && pr < ROWS) run[c][r] = run[pc][pr] + 1;
                    else run[c][r] = 1;
                    if (run[c][r] >= WIN_LEN) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic void model_resolve();
        bit red, yel, mv, ot, full;
        red = has_run(1);
        yel = has_run(0);
        mv = m_player ? red : yel;
        ot = m_player ? yel : red;
        full = 1'b1;
        for (int c = 0; c < COLS; c++) if (m_h[c] != ROWS) full = 1'b0;
        if (mv || ot) begin
            m_wv = 1'b1; m_over = 1'b1;
            m_w = mv ? m_player : !m_player;
            if (m_w) m_sr = (m_sr < 15) ? m_sr + 1 : 15;
            else     m_sy = (m_sy < 15) ? m_sy + 1 : 15;
        end else if (full) begin
            m_draw = 1'b1; m_over = 1'b1;
        end else begin
            m_player = !m_player;
        end
    endfunction

    task automatic check_status(input string tag);
        logic [5:0] got, exp;
        got = {move_ready, game_over, winner_valid, winner, draw, cur_player};
        exp = {!m_over, m_over, m_wv, m_w, m_draw, m_player};
        n_checks++;
        if (got !== exp) $display("FAIL %s status rdy/over/wv/w/draw/pl got %b want %b", tag, got, exp);
        else n_pass++;
        n_checks++;
        if (score_red !== m_sr[3:0] || score_yellow !== m_sy[3:0])
            $display("FAIL %s scores got %0d/%0d want %0d/%0d", tag, score_red, score_yellow, m_sr, m_sy);
        else n_pass++;
    endtask

    task automatic apply_move(input int col, input bit pop);
        bit ok;
        ok = model_legal(col, pop);
        move_valid = 1'b1; move_col = col[2:0]; move_pop = pop;
        @(posedge clk); #1;
        move_valid = 1'b0;
        n_checks++;
        if ({move_ack, move_err} !== {ok, !ok})
            $display("FAIL move c%0d p%0d ack/err got %b%b want %b%b", col, pop, move_ack, move_err, ok, !ok);
        else n_pass++;
        if (ok) begin
            model_apply(col, pop);
            n_checks++;
            if ({busy, move_ready} !== 2'b10) $display("FAIL scan_start busy/ready got %b%b", busy, move_ready);
            else n_pass++;
            repeat (NCELL - 1) @(posedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b1) $display("FAIL scan_len busy early end got %b want 1", busy);
            else n_pass++;
            @(posedge clk); #1;
            model_resolve();
        end
        check_status("after_move");
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_clear();
        check_status("new_game");
    endtask

    task automatic check_board(input string tag);
        logic [1:0] exp;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++) begin
                rd_col = c[2:0]; rd_row = r[2:0];
                @(posedge clk); #1;
                if (c < COLS && r < ROWS) exp = {m_board[c][r] >= 0, m_board[c][r] == 1};
                else exp = 2'b00;
                n_checks++;
                if ({rd_occupied, rd_color} !== exp)
                    $display("FAIL %s cell(%0d,%0d) occ/col got %b%b want %b", tag, c, r, rd_occupied, rd_color, exp);
                else n_pass++;
            end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({move_ready, move_ack, move_err, busy, game_over, winner_valid, winner, draw, cur_player} !== 9'b100000001)
            $display("FAIL reset flags got %b want 100000001",
                     {move_ready, move_ack, move_err, busy, game_over, winner_valid, winner, draw, cur_player});
        else n_pass++;
        n_checks++;
        if ({score_red, score_yellow, rd_occupied, rd_color} !== 10'd0)
            $display("FAIL reset scores/rd got %0d %0d %b%b want 0", score_red, score_yellow, rd_occupied, rd_color);
        else n_pass++;
        check_board("reset");
    endtask

    task automatic test_vertical_win();
        int seq [7] = '{0, 1, 0, 1, 0, 1, 0};
        do_new_game();
        foreach (seq[i]) apply_move(seq[i], 1'b0);
        n_checks++;
        if ({winner_valid, winner, score_red} !== {2'b11, 4'd1})
            $display("FAIL vertical win wv/w/score got %b%b %0d want 11 1", winner_valid, winner, score_red);
        else n_pass++;
        move_valid = 1'b1; move_col = 3'd3; move_pop = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if ({move_ack, move_err, move_ready, game_over} !== 4'b0001)
                $display("FAIL over_ignore ack/err/rdy/over got %b%b%b%b want 0001", move_ack, move_err, move_ready, game_over);
            else n_pass++;
        end
        move_valid = 1'b0;
        check_board("vertical");
    endtask

    task automatic test_horizontal_and_diagonal();
        int h [7] = '{0, 6, 1, 6, 2, 6, 3};
        int d [10] = '{2, 1, 3, 2, 4, 4, 3, 3, 4, 4};
        do_new_game();
        foreach (h[i]) apply_move(h[i], 1'b0);
        do_new_game();
        foreach (d[i]) apply_move(d[i], 1'b0);
        n_checks++;
        if ({winner_valid, winner, score_yellow} !== {2'b10, 4'd1})
            $display("FAIL diagonal yellow wv/w/score got %b%b %0d want 10 1", winner_valid, winner, score_yellow);
        else n_pass++;
        check_board("diagonal");
    endtask

    task automatic test_errors_and_pop();
        do_new_game();
        apply_move(7, 1'b0);
        repeat (6) apply_move(5, 1'b0);
        apply_move(5, 1'b0);
        apply_move(0, 1'b0);
        apply_move(2, 1'b0);
        apply_move(2, 1'b1);
        repeat (3) apply_move(3, 1'b0);
        apply_move(6, 1'b0);
        apply_move(3, 1'b1);
        n_checks++;
        if (m_h[3] != 2 || move_err !== 1'b0) $display("FAIL pop height model %0d want 2", m_h[3]);
        else n_pass++;
        check_board("pop");
    endtask

    task automatic test_new_game_mid_check();
        do_new_game();
        apply_move(4, 1'b0);
        move_valid = 1'b1; move_col = 3'd0; move_pop = 1'b0;
        @(posedge clk); #1;
        move_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_clear();
        check_status("ng_mid_check");
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ng_mid_check busy got %b want 0", busy);
        else n_pass++;
        apply_move(1, 1'b0);
        new_game = 1'b1; move_valid = 1'b1; move_col = 3'd2; move_pop = 1'b0;
        @(posedge clk); #1;
        new_game = 1'b0; move_valid = 1'b0;
        model_clear();
        n_checks++;
        if ({move_ack, move_err} !== 2'b00) $display("FAIL ng_override ack/err got %b%b want 00", move_ack, move_err);
        else n_pass++;
        check_board("ng_override");
    endtask

    task automatic test_clear_score_on_win();
        int seq [6] = '{0, 1, 0, 1, 0, 1};
        do_new_game();
        foreach (seq[i]) apply_move(seq[i], 1'b0);
        move_valid = 1'b1; move_col = 3'd0; move_pop = 1'b0;
        @(posedge clk); #1;
        move_valid = 1'b0;
        model_apply(0, 1'b0);
        repeat (NCELL - 1) @(posedge clk);
        #1;
        clear_score = 1'b1;
        @(posedge clk); #1;
        clear_score = 1'b0;
        model_resolve();
        m_sr = 0; m_sy = 0;
        check_status("clear_on_win");
    endtask

    task automatic test_random();
        int col;
        bit pop;
        for (int g = 0; g < 4; g++) begin
            do_new_game();
            for (int i = 0; i < 50 && !m_over; i++) begin
                col = $urandom_range(0, 7);
                pop = ($urandom_range(0, 3) == 0);
                apply_move(col, pop);
            end
            check_board("random");
        end
    endtask

    task automatic test_small_draw();
        int cols [4] = '{0, 0, 1, 1};
        foreach (cols[i]) begin
            s_move_valid = 1'b1; s_move_col = cols[i][0:0]; s_move_pop = 1'b0;
            @(posedge clk); #1;
            s_move_valid = 1'b0;
            n_checks++;
            if (s_move_ack !== 1'b1) $display("FAIL small ack move %0d got %b want 1", i, s_move_ack);
            else n_pass++;
            repeat (4) @(posedge clk);
            #1;
            n_checks++;
            if (i < 3 && {s_move_ready, s_draw, s_game_over} !== 3'b100)
                $display("FAIL small mid rdy/draw/over got %b%b%b want 100", s_move_ready, s_draw, s_game_over);
            else if (i == 3 && {s_move_ready, s_draw, s_game_over, s_winner_valid} !== 4'b0110)
                $display("FAIL small draw rdy/draw/over/wv got %b%b%b%b want 0110",
                         s_move_ready, s_draw, s_game_over, s_winner_valid);
            else n_pass++;
        end
        n_checks++;
        if ({s_score_red, s_score_yellow} !== 8'd0)
            $display("FAIL small scores got %0d/%0d want 0/0", s_score_red, s_score_yellow);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; move_valid = 1'b0; move_col = 3'd0; move_pop = 1'b0;
        new_game = 1'b0; clear_score = 1'b0; rd_col = 3'd0; rd_row = 3'd0;
        s_move_valid = 1'b0; s_move_col = 1'b0; s_move_pop = 1'b0;
        s_new_game = 1'b0; s_clear_score = 1'b0; s_rd_col = 1'b0; s_rd_row = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_vertical_win();
        test_horizontal_and_diagonal();
        test_errors_and_pop();
        test_new_game_mid_check();
        test_clear_score_on_win();
        test_random();
        test_small_draw();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
